// File: rtl/mux2_bus_arbiter.sv
// mux2_bus_arbiter: round-robin owner of a shared 2:1 mux datapath with registered dout/valid
module mux2_bus_arbiter #(
  parameter int DATA_W = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              tmo_a,
  output logic              tmo_b
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;
  logic [1:0]        r_state;
  logic [1:0]        w_nxt;
  logic              r_last;
  logic [DATA_W-1:0] r_dout;
  logic              r_vld;
  logic              r_tmo_a;
  logic              r_tmo_b;
  logic              w_pre_a;
  logic              w_pre_b;
`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] r_hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_hold <= '0;
    else r_hold <= (w_nxt != r_state) ? '0 :
                   (r_state != IDLE && r_hold != HW'(MAX_HOLD)) ? r_hold + 1'b1 : r_hold;
  assign w_pre_a = (r_state == OWN_A) & req_a & req_b & (r_hold == HW'(MAX_HOLD - 1));
  assign w_pre_b = (r_state == OWN_B) & req_a & req_b & (r_hold == HW'(MAX_HOLD - 1));
`else
  assign w_pre_a = 1'b0;
  assign w_pre_b = 1'b0;
`endif
  always_comb
    w_nxt = (r_state == OWN_A) ? ((!req_a || w_pre_a) ? (req_b ? OWN_B : IDLE) : OWN_A) :
            (r_state == OWN_B) ? ((!req_b || w_pre_b) ? (req_a ? OWN_A : IDLE) : OWN_B) :
            (req_a && (!req_b || r_last)) ? OWN_A : req_b ? OWN_B : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      r_tmo_a <= 1'b0;
      r_tmo_b <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_last  <= (r_state == OWN_A && w_nxt != OWN_A) ? 1'b0 :
                 (r_state == OWN_B && w_nxt != OWN_B) ? 1'b1 : r_last;
      r_dout  <= sel ? din_b : din_a;
      r_vld   <= (gnt_a & req_a) | (gnt_b & req_b);
      r_tmo_a <= w_pre_a;
      r_tmo_b <= w_pre_b;
    end
  assign gnt_a    = (r_state == OWN_A);
  assign gnt_b    = (r_state == OWN_B);
  assign sel      = (r_state == OWN_B);
  assign dout     = r_dout;
  assign dout_vld = r_vld;
  assign tmo_a    = r_tmo_a;
  assign tmo_b    = r_tmo_b;
endmodule
